// File: rtl/hood_pkg.sv
// Shared mode encodings, fan-level constants and default durations for the hood mode controller.
// Latency: none (types and constants only).
// Backpressure: none.
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_STANDBY = 3'd1,
    MODE_MENU    = 3'd2,
    MODE_LEVEL1  = 3'd3,
    MODE_LEVEL2  = 3'd4,
    MODE_LEVEL3  = 3'd5,
    MODE_RETURN  = 3'd6,
    MODE_CLEAN   = 3'd7
  } mode_e;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_MED  = 2'd2;
  localparam logic [1:0] FAN_HIGH = 2'd3;

  localparam int HURRICANE_SEC_DEF = 60;
  localparam int RETURN_SEC_DEF    = 60;
  localparam int CLEAN_SEC_DEF     = 180;

  // Fan speed implied by an operating mode; RETURN keeps the fan at full speed.
  function automatic logic [1:0] fan_for_mode(input mode_e m);
    case (m)
      MODE_LEVEL1: fan_for_mode = FAN_LOW;
      MODE_LEVEL2: fan_for_mode = FAN_MED;
      MODE_LEVEL3: fan_for_mode = FAN_HIGH;
      MODE_RETURN: fan_for_mode = FAN_HIGH;
      default:     fan_for_mode = FAN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Seconds countdown: a prescaler divides clk down to 1 s ticks that decrement count to zero.
// Latency: load visible on count next cycle; expire is combinational, asserted the cycle before count reaches 0.
// Backpressure: none; load always wins and restarts the prescaler.
module sec_timer #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       expire
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          sec_tick;

  // The prescaler only runs while there is time left, so an idle timer never underflows.
  assign sec_tick = (count != 8'd0) && (presc == PRESC_MAX);
  assign expire   = sec_tick && (count == 8'd1);

  // Prescaler and seconds counter; a load restarts the second from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      count <= 8'd0;
    end else if (load) begin
      presc <= '0;
      count <= load_val;
    end else if (count != 8'd0) begin
      if (sec_tick) begin
        presc <= '0;
        count <= count - 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/hood_mode_controller.sv
// Range-hood mode FSM: standby/menu/extraction levels/self-clean with timed LEVEL3, RETURN and CLEAN.
// Latency: key pulse or power change at cycle t shows on mode/fan_level at t+1; all outputs registered.
// Backpressure: none; keys not valid in the current state are dropped.
module hood_mode_controller
  import hood_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int HURRICANE_SEC = HURRICANE_SEC_DEF,
  parameter int RETURN_SEC    = RETURN_SEC_DEF,
  parameter int CLEAN_SEC     = CLEAN_SEC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_state,
  input  logic       menu_key,
  input  logic       lvl1_key,
  input  logic       lvl2_key,
  input  logic       lvl3_key,
  input  logic       clean_key,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] countdown_sec,
  output logic       hurricane_used,
  output logic       clean_done
);

  mode_e      state;
  mode_e      next_state;
  logic       tmr_load;
  logic [7:0] tmr_load_val;
  logic       tmr_expire;
  logic       lvl3_ok;

  assign lvl3_ok = lvl3_key && !hurricane_used;
  assign mode    = state;

  // Next-state selection; power loss overrides everything, then expiry, then keys by priority.
  always_comb begin
    next_state = state;
    if (!power_state) begin
      next_state = MODE_OFF;
    end else begin
      case (state)
        MODE_OFF:     next_state = MODE_STANDBY;
        MODE_STANDBY: if (menu_key) next_state = MODE_MENU;
        MODE_MENU: begin
          if (menu_key)       next_state = MODE_STANDBY;
          else if (lvl3_ok)   next_state = MODE_LEVEL3;
          else if (lvl2_key)  next_state = MODE_LEVEL2;
          else if (lvl1_key)  next_state = MODE_LEVEL1;
          else if (clean_key) next_state = MODE_CLEAN;
        end
        MODE_LEVEL1, MODE_LEVEL2: begin
          if (menu_key)      next_state = MODE_STANDBY;
          else if (lvl3_ok)  next_state = MODE_LEVEL3;
          else if (lvl2_key) next_state = MODE_LEVEL2;
          else if (lvl1_key) next_state = MODE_LEVEL1;
        end
        MODE_LEVEL3: begin
          if (tmr_expire)    next_state = MODE_LEVEL2;
          else if (menu_key) next_state = MODE_RETURN;
        end
        MODE_RETURN: if (tmr_expire) next_state = MODE_STANDBY;
        MODE_CLEAN:  if (tmr_expire) next_state = MODE_STANDBY;
        default:     next_state = MODE_OFF;
      endcase
    end
  end

  // Every state change reloads the timer: timed states get their duration, others get 0,
  // which also discards a countdown cut short by power loss or by leaving LEVEL3 early.
  always_comb begin
    tmr_load     = (next_state != state);
    tmr_load_val = 8'd0;
    case (next_state)
      MODE_LEVEL3: tmr_load_val = 8'(HURRICANE_SEC);
      MODE_RETURN: tmr_load_val = 8'(RETURN_SEC);
      MODE_CLEAN:  tmr_load_val = 8'(CLEAN_SEC);
      default:     tmr_load_val = 8'd0;
    endcase
  end

  sec_timer #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (countdown_sec),
    .expire   (tmr_expire)
  );

  // State, fan level and status flags, all registered from the next-state decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= MODE_OFF;
      fan_level      <= FAN_OFF;
      hurricane_used <= 1'b0;
      clean_done     <= 1'b0;
    end else begin
      state      <= next_state;
      fan_level  <= fan_for_mode(next_state);
      clean_done <= power_state && (state == MODE_CLEAN) && tmr_expire;
      if (!power_state)
        hurricane_used <= 1'b0;
      else if (next_state == MODE_LEVEL3)
        hurricane_used <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hood_mode_controller.sv
// Directed bench for hood_mode_controller with a 10-cycle second.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_hood_mode_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_state;
  logic       menu_key, lvl1_key, lvl2_key, lvl3_key, clean_key;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] countdown_sec;
  logic       hurricane_used;
  logic       clean_done;

  int tests_run    = 0;
  int tests_failed = 0;

  hood_mode_controller #(
    .TICKS_PER_SEC(10),
    .HURRICANE_SEC(60),
    .RETURN_SEC   (60),
    .CLEAN_SEC    (180)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .power_state   (power_state),
    .menu_key      (menu_key),
    .lvl1_key      (lvl1_key),
    .lvl2_key      (lvl2_key),
    .lvl3_key      (lvl3_key),
    .clean_key     (clean_key),
    .mode          (mode),
    .fan_level     (fan_level),
    .countdown_sec (countdown_sec),
    .hurricane_used(hurricane_used),
    .clean_done    (clean_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Pulse the given keys for exactly one sampled edge.
  task automatic press(input logic m, input logic k1, input logic k2, input logic k3, input logic kc);
    menu_key = m; lvl1_key = k1; lvl2_key = k2; lvl3_key = k3; clean_key = kc;
    tick(1);
    menu_key = 0; lvl1_key = 0; lvl2_key = 0; lvl3_key = 0; clean_key = 0;
  endtask

  initial begin
    reset = 1; power_state = 0;
    menu_key = 0; lvl1_key = 0; lvl2_key = 0; lvl3_key = 0; clean_key = 0;
    tick(2);
    check("rst_mode", mode, 0);
    check("rst_fan", fan_level, 0);
    check("rst_cd", countdown_sec, 0);
    check("rst_used", hurricane_used, 0);
    check("rst_done", clean_done, 0);
    reset = 0;
    tick(1);
    check("off_hold", mode, 0);

    power_state = 1;
    tick(1);
    check("power_standby", mode, 1);
    press(0, 1, 0, 0, 0);
    check("standby_ignores_lvl1", mode, 1);
    press(1, 0, 0, 0, 0);
    check("menu", mode, 2);
    press(0, 0, 1, 0, 0);
    check("lvl2_mode", mode, 4);
    check("lvl2_fan", fan_level, 2);

    // Hurricane run to expiry.
    press(1, 0, 0, 0, 0);
    check("lvl2_menu_standby", mode, 1);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    check("l3_mode", mode, 5);
    check("l3_cd", countdown_sec, 60);
    check("l3_used", hurricane_used, 1);
    check("l3_fan", fan_level, 3);
    tick(10);
    check("l3_cd_after_1s", countdown_sec, 59);
    tick(589);
    check("l3_last_cycle_mode", mode, 5);
    check("l3_last_cycle_cd", countdown_sec, 1);
    tick(1);
    check("l3_expire_mode", mode, 4);
    check("l3_expire_cd", countdown_sec, 0);
    check("l3_expire_fan", fan_level, 2);
    press(0, 0, 0, 1, 0);
    check("l3_used_ignored", mode, 4);

    // Power cycle, then LEVEL3 -> RETURN -> STANDBY.
    power_state = 0;
    tick(1);
    check("pwr_off_mode", mode, 0);
    check("pwr_off_used", hurricane_used, 0);
    power_state = 1;
    tick(1);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    check("l3_again", mode, 5);
    tick(5);
    press(1, 0, 0, 0, 0);
    check("ret_mode", mode, 6);
    check("ret_fan", fan_level, 3);
    check("ret_cd", countdown_sec, 60);
    tick(599);
    check("ret_last_mode", mode, 6);
    tick(1);
    check("ret_done_mode", mode, 1);
    check("ret_done_fan", fan_level, 0);
    check("ret_done_cd", countdown_sec, 0);

    // Self-clean.
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    check("clean_mode", mode, 7);
    check("clean_cd", countdown_sec, 180);
    check("clean_fan", fan_level, 0);
    press(1, 0, 0, 0, 0);
    check("clean_ignores_menu", mode, 7);
    tick(1798);
    check("clean_last_mode", mode, 7);
    check("clean_last_done", clean_done, 0);
    tick(1);
    check("clean_exit_mode", mode, 1);
    check("clean_exit_done", clean_done, 1);
    tick(1);
    check("clean_done_single", clean_done, 0);

    // Power drop mid-countdown discards the timer.
    power_state = 0;
    tick(1);
    power_state = 1;
    tick(1);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    tick(300);
    check("l3_mid_cd", countdown_sec, 30);
    power_state = 0;
    tick(1);
    check("drop_mode", mode, 0);
    check("drop_cd", countdown_sec, 0);
    check("drop_used", hurricane_used, 0);
    check("drop_fan", fan_level, 0);
    power_state = 1;
    tick(1);
    check("repower_mode", mode, 1);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    check("repower_l3", mode, 5);
    check("repower_cd", countdown_sec, 60);

    // Expiry beats a menu key on the same cycle.
    tick(599);
    press(1, 0, 0, 0, 0);
    check("expiry_beats_menu", mode, 4);

    // Simultaneous keys in MENU: lvl1 beats clean.
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    check("menu_again", mode, 2);
    press(0, 1, 0, 0, 1);
    check("lvl1_over_clean", mode, 3);
    check("lvl1_fan", fan_level, 1);
    press(0, 0, 0, 0, 1);
    check("lvl1_ignores_clean", mode, 3);
    press(0, 1, 1, 0, 0);
    check("lvl2_over_lvl1", mode, 4);
    press(0, 1, 0, 0, 0);
    check("lvl2_to_lvl1", mode, 3);

    // Reset from LEVEL1 with power still on.
    reset = 1;
    tick(1);
    check("rst2_mode", mode, 0);
    check("rst2_fan", fan_level, 0);
    check("rst2_cd", countdown_sec, 0);
    check("rst2_used", hurricane_used, 0);
    check("rst2_done", clean_done, 0);
    reset = 0;
    tick(1);
    check("rst2_release", mode, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hood_mode_controller.md
# hood_mode_controller

Sequences the range-hood operating modes once the hood is powered on by the gesture power controller. It takes debounced single-cycle key pulses and the registered `power_state`, and runs a mode FSM: standby, menu, extraction levels 1/2/3, and self-clean. It drives the fan level, the mode code and a seconds countdown for the display and motor blocks.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: clock cycles per second at 100 MHz.
- `HURRICANE_SEC`, default 60: seconds of level-3 run.
- `RETURN_SEC`, default 60: level-3 exit delay, with fan still on, before standby.
- `CLEAN_SEC`, default 180: self-clean duration.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `power_state` in 1: 1 = hood on.
- `menu_key` in 1: one-cycle pulse.
- `lvl1_key`, `lvl2_key`, `lvl3_key`, `clean_key` in 1 each: one-cycle pulses.
- `mode` out 3: current state code.
- `fan_level` out 2: 0 = off, 1, 2, 3.
- `countdown_sec` out 8: remaining seconds of the active timed state, else 0.
- `hurricane_used` out 1: level 3 already consumed this power cycle.
- `clean_done` out 1: one-cycle pulse when self-clean completes.

## Operation
- States and `mode` codes: OFF=0, STANDBY=1, MENU=2, LEVEL1=3, LEVEL2=4, LEVEL3=5, RETURN=6, CLEAN=7.
- `fan_level` per state: LEVEL1→1, LEVEL2→2, LEVEL3→3, RETURN→3, all others→0.
- OFF → STANDBY when `power_state`=1.
- Any state → OFF when `power_state`=0. This takes priority over everything else. It also clears the timers and `hurricane_used`.
- STANDBY: `menu_key` → MENU. All other keys are ignored.
- MENU:
  - `lvl1_key` → LEVEL1; `lvl2_key` → LEVEL2.
  - `lvl3_key` → LEVEL3 only if `hurricane_used`=0; otherwise it is ignored.
  - `clean_key` → CLEAN.
  - `menu_key` → STANDBY.
- LEVEL1 / LEVEL2:
  - `lvl1_key` / `lvl2_key` switch between the two levels directly.
  - `lvl3_key` → LEVEL3 if not used.
  - `menu_key` → STANDBY immediately.
  - `clean_key` is ignored.
- LEVEL3:
  - On entry, load `HURRICANE_SEC` and set `hurricane_used`=1.
  - At expiry → LEVEL2.
  - `menu_key` → RETURN and loads `RETURN_SEC`.
  - Level keys are ignored.
- RETURN: at expiry → STANDBY. All keys are ignored.
- CLEAN: at expiry → STANDBY and `clean_done` pulses for 1 cycle. All keys are ignored.
- Simultaneous key priority: `menu_key` > `lvl3_key` > `lvl2_key` > `lvl1_key` > `clean_key`. Only the highest-priority valid key acts.
- Timer arithmetic:
  - On entry to a timed state, the prescaler is cleared to 0 and `countdown_sec` is loaded with N.
  - Each time the prescaler reaches `TICKS_PER_SEC`-1, it wraps to 0 and `countdown_sec` decrements.
  - The tick that takes `countdown_sec` from 1 to 0 triggers the exit.
  - `countdown_sec` is 8-bit unsigned; N must be ≤255. It never underflows.
- Reset: state OFF, `fan_level`=0, `countdown_sec`=0, `hurricane_used`=0, `clean_done`=0, prescaler=0.

## Timing
- All outputs are registered.
- A key pulse in cycle t is reflected on `mode`/`fan_level` in cycle t+1.
- A timed state entered at cycle t holds for exactly N×`TICKS_PER_SEC` cycles. The next state is visible at t + N×`TICKS_PER_SEC`.
- `power_state` falling is reflected as OFF one cycle later, even mid-countdown. The countdown is discarded.
- `power_state` returning high re-enters STANDBY with `hurricane_used`=0.
- `reset` asserted mid-countdown returns to OFF the next cycle, regardless of `power_state`.
- If a key press and a timer expiry land on the same cycle: expiry wins in LEVEL3, so the state goes to LEVEL2 and `menu_key` is dropped.

## Structure
- Shared package `hood_pkg`:
  - mode encodings (OFF…CLEAN);
  - fan-level constants;
  - default time constants (`HURRICANE_SEC`, `RETURN_SEC`, `CLEAN_SEC`).
- Sub-module `sec_timer`:
  - parameter `TICKS_PER_SEC`;
  - inputs `clk`, `reset`, `load`, `load_val[7:0]`;
  - outputs `count[7:0]`, `expire` (one-cycle pulse);
  - this block instantiates it once.
- Top-level FSM: one registered state, plus combinational next-state logic.

## Test plan (sim with `TICKS_PER_SEC`=10)
- Reset, then `power_state`=1 → `mode`=1 next cycle. Then `menu_key` and `lvl2_key` pulses → `mode`=4, `fan_level`=2.
- From MENU, `lvl3_key` → `mode`=5, `countdown_sec`=60, `hurricane_used`=1. After exactly 600 cycles → `mode`=4. A second `lvl3_key` → no change.
- In LEVEL3, `menu_key` → `mode`=6, `fan_level`=3. 600 cycles later → `mode`=1, `fan_level`=0.
- From MENU, `clean_key` → `mode`=7, `countdown_sec`=180. After 1800 cycles → `mode`=1 and `clean_done`=1 for exactly one cycle.
- In LEVEL3 with `countdown_sec`=30, drop `power_state` → `mode`=0, `countdown_sec`=0, `hurricane_used`=0. Re-raise `power_state`, then `menu_key` + `lvl3_key` → `mode`=5 is accepted.
- In MENU, assert `lvl1_key` and `clean_key` in the same cycle → `mode`=3.
- In LEVEL1, assert `reset` → all outputs at reset values next cycle.
